// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Instruction-fetch sequencer between the instruction SRAM and the
//            instruction FIFO of the 12-bit processor. It generates the
//            sequential fetch PC and issues SRAM reads (1-cycle latency). It
//            enqueues returned {addr, data} pairs and throttles issue with a
//            credit count so the FIFO never overflows. It also clears the FIFO
//            while idle and on branch redirect, and discards wrong-path
//            responses.
// Ports    : clk              - clock, all state on posedge
//            reset_n_i        - asynchronous active-low reset
//            start_i          - begin fetching at start_addr_i (IDLE only)
//            start_addr_i     - initial PC
//            redirect_i       - branch/jump redirect request
//            redirect_addr_i  - redirect target PC
//            halt_i           - stop issuing new fetches
//            deque_i          - consumer pops FIFO head
//            sram_re_o        - SRAM read enable
//            sram_addr_o      - SRAM read address (current PC)
//            sram_data_i      - SRAM read data, valid the cycle after a read
//            fifo_enque_o     - FIFO enqueue
//            fifo_addr_o      - FIFO write address
//            fifo_data_o      - FIFO write data
//            fifo_deque_o     - FIFO dequeue (filtered deque_i)
//            fifo_clear_o     - FIFO clear
//            busy_o           - sequencer not idle
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter int I_WIDTH  = 12,
  parameter int A_WIDTH  = 8,
  parameter int LG_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic [A_WIDTH-1:0] start_addr_i,
  input  logic               redirect_i,
  input  logic [A_WIDTH-1:0] redirect_addr_i,
  input  logic               halt_i,
  input  logic               deque_i,
  output logic               sram_re_o,
  output logic [A_WIDTH-1:0] sram_addr_o,
  input  logic [I_WIDTH-1:0] sram_data_i,
  output logic               fifo_enque_o,
  output logic [A_WIDTH-1:0] fifo_addr_o,
  output logic [I_WIDTH-1:0] fifo_data_o,
  output logic               fifo_deque_o,
  output logic               fifo_clear_o,
  output logic               busy_o
);

  // One extra bit so occupancy plus an in-flight response never wraps.
  localparam int               CNT_W = LG_DEPTH + 1;
  localparam logic [CNT_W-1:0] C_CAP = CNT_W'((1 << LG_DEPTH) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [A_WIDTH-1:0] r_pc;
  logic [A_WIDTH-1:0] w_pc_nxt;
  logic [CNT_W-1:0]   r_occ;
  logic [CNT_W-1:0]   w_occ_nxt;
  logic               r_rsp_valid;
  logic [A_WIDTH-1:0] r_rsp_addr;

  logic               w_issue_ok;
  logic               w_issue;
  logic               w_enque;
  logic               w_deque;
  logic               w_active;

  // Credit ignores a same-cycle dequeue: the freed slot is only reused one
  // cycle later, which keeps the check off the consumer's timing path.
  assign w_issue_ok = (r_occ + CNT_W'(r_rsp_valid)) < C_CAP;
  assign w_active   = (r_state == S_FETCH) || (r_state == S_HALT);

  assign w_issue = (r_state == S_FETCH) && w_issue_ok && !halt_i && !redirect_i;

  // A response returning in the redirect cycle belongs to the old path.
  assign w_enque = r_rsp_valid && w_active &&
                   !((r_state == S_FETCH) && redirect_i);

  // Dequeues on an empty FIFO are dropped so occupancy cannot underflow.
  assign w_deque = deque_i && (r_occ != '0) && w_active;

  assign sram_re_o    = w_issue;
  assign sram_addr_o  = r_pc;
  assign fifo_enque_o = w_enque;
  assign fifo_addr_o  = r_rsp_addr;
  assign fifo_data_o  = sram_data_i;
  assign fifo_deque_o = w_deque;
  assign fifo_clear_o = (r_state == S_IDLE) || (r_state == S_FLUSH);
  assign busy_o       = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = start_addr_i;
        end
      end
      S_FETCH: begin
        // Redirect takes priority over halt in the same cycle.
        if (redirect_i) begin
          w_state_nxt = S_FLUSH;
          w_pc_nxt    = redirect_addr_i;
        end else if (halt_i) begin
          w_state_nxt = S_HALT;
        end else if (w_issue) begin
          w_pc_nxt = r_pc + A_WIDTH'(1);
        end
      end
      S_HALT: begin
        if (redirect_i) begin
          w_state_nxt = S_FLUSH;
          w_pc_nxt    = redirect_addr_i;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_FETCH;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The FIFO is held clear in IDLE and FLUSH, so occupancy tracks that.
  always_comb begin
    w_occ_nxt = r_occ;
    if (fifo_clear_o) begin
      w_occ_nxt = '0;
    end else begin
      w_occ_nxt = r_occ + CNT_W'(w_enque) - CNT_W'(w_deque);
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_occ       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_occ       <= w_occ_nxt;
      r_rsp_valid <= w_issue;
      if (w_issue) begin
        r_rsp_addr <= r_pc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Directed self-checking bench for fetch_ctrl. Includes a small
//            SRAM model (1-cycle read) and a reference FIFO that follows the
//            DUT's enqueue/dequeue/clear strobes and logs traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam int I_WIDTH  = 12;
  localparam int A_WIDTH  = 8;
  localparam int LG_DEPTH = 2;
  localparam int CAP      = (1 << LG_DEPTH) - 1;

  logic               clk = 1'b0;
  logic               reset_n_i;
  logic               start_i;
  logic [A_WIDTH-1:0] start_addr_i;
  logic               redirect_i;
  logic [A_WIDTH-1:0] redirect_addr_i;
  logic               halt_i;
  logic               deque_i;
  logic               sram_re_o;
  logic [A_WIDTH-1:0] sram_addr_o;
  logic [I_WIDTH-1:0] sram_data_i = '0;
  logic               fifo_enque_o;
  logic [A_WIDTH-1:0] fifo_addr_o;
  logic [I_WIDTH-1:0] fifo_data_o;
  logic               fifo_deque_o;
  logic               fifo_clear_o;
  logic               busy_o;

  int checks = 0;
  int errors = 0;

  logic [A_WIDTH-1:0] mdl_addr[$];
  logic [A_WIDTH-1:0] enq_log[$];
  logic [A_WIDTH-1:0] deq_log[$];
  int overflow_cnt  = 0;
  int underflow_cnt = 0;
  int data_err_cnt  = 0;

  fetch_ctrl #(
    .I_WIDTH (I_WIDTH),
    .A_WIDTH (A_WIDTH),
    .LG_DEPTH(LG_DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n_i      (reset_n_i),
    .start_i        (start_i),
    .start_addr_i   (start_addr_i),
    .redirect_i     (redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .halt_i         (halt_i),
    .deque_i        (deque_i),
    .sram_re_o      (sram_re_o),
    .sram_addr_o    (sram_addr_o),
    .sram_data_i    (sram_data_i),
    .fifo_enque_o   (fifo_enque_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_data_o    (fifo_data_o),
    .fifo_deque_o   (fifo_deque_o),
    .fifo_clear_o   (fifo_clear_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [I_WIDTH-1:0] mem_word(input logic [A_WIDTH-1:0] a);
    return {a[3:0], ~a};
  endfunction

  // SRAM: data for the address read this cycle appears next cycle.
  always @(posedge clk) begin
    sram_data_i <= sram_re_o ? mem_word(sram_addr_o) : '0;
  end

  // Reference FIFO following the DUT strobes.
  always @(posedge clk) begin
    if (fifo_clear_o) begin
      mdl_addr.delete();
    end else begin
      if (fifo_deque_o) begin
        if (mdl_addr.size() == 0) underflow_cnt++;
        else deq_log.push_back(mdl_addr.pop_front());
      end
      if (fifo_enque_o) begin
        if (mdl_addr.size() >= CAP) overflow_cnt++;
        if (fifo_data_o !== mem_word(fifo_addr_o)) data_err_cnt++;
        mdl_addr.push_back(fifo_addr_o);
        enq_log.push_back(fifo_addr_o);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    step();
    reset_n_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mark;
    int mark2;
    int bad;
    logic [A_WIDTH-1:0] a;

    reset_n_i       = 1'b1;
    start_i         = 1'b0;
    start_addr_i    = '0;
    redirect_i      = 1'b0;
    redirect_addr_i = '0;
    halt_i          = 1'b0;
    deque_i         = 1'b0;

    // Reset values
    #2 reset_n_i = 1'b0;
    #1;
    check("rst_re",    sram_re_o,    1'b0);
    check("rst_enq",   fifo_enque_o, 1'b0);
    check("rst_deq",   fifo_deque_o, 1'b0);
    check("rst_clear", fifo_clear_o, 1'b1);
    check("rst_busy",  busy_o,       1'b0);
    step();
    step();
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("idle_clear", fifo_clear_o, 1'b1);
      check("idle_re",    sram_re_o,    1'b0);
      check("idle_busy",  busy_o,       1'b0);
      step();
    end

    // Start at 0x10, no consumer: three reads then credit stall
    start_i = 1'b1; start_addr_i = 8'h10;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      check("fill_re", sram_re_o, (i < 3) ? 1'b1 : 1'b0);
      if (i < 3) check("fill_addr", sram_addr_o, 8'h10 + 8'(i));
      step();
    end
    step();
    mid();
    check("fill_re_stall", sram_re_o, 1'b0);
    check("fill_busy", busy_o, 1'b1);
    check("fill_size", mdl_addr.size(), 3);
    check("fill_q0", mdl_addr[0], 8'h10);
    check("fill_q1", mdl_addr[1], 8'h11);
    check("fill_q2", mdl_addr[2], 8'h12);
    step();

    // Start at 0x10 with continuous dequeue, then redirect to 0x40
    do_reset();
    start_i = 1'b1; start_addr_i = 8'h10; deque_i = 1'b1;
    step();
    start_i = 1'b0;
    mark = deq_log.size();
    for (int i = 0; i < 6; i++) begin
      mid();
      check("stream_re",   sram_re_o,   1'b1);
      check("stream_addr", sram_addr_o, 8'h10 + 8'(i));
      step();
    end
    // Read of 0x15 is in flight now.
    redirect_i = 1'b1; redirect_addr_i = 8'h40;
    mid();
    check("redir_re",    sram_re_o,    1'b0);
    check("redir_enq",   fifo_enque_o, 1'b0);
    check("redir_clear", fifo_clear_o, 1'b0);
    step();
    redirect_i = 1'b0;
    mid();
    check("flush_clear", fifo_clear_o, 1'b1);
    check("flush_re",    sram_re_o,    1'b0);
    check("flush_busy",  busy_o,       1'b1);
    mark2 = deq_log.size();
    step();
    mid();
    check("refill_clear", fifo_clear_o, 1'b0);
    check("refill_re",    sram_re_o,    1'b1);
    check("refill_addr",  sram_addr_o,  8'h40);
    step();
    step();
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      check("stream_head", deq_log[mark + i], 8'h10 + 8'(i));
    end
    check("refill_head", deq_log[mark2], 8'h40);
    bad = 0;
    foreach (enq_log[k]) if (enq_log[k] == 8'h15) bad++;
    check("killed_0x15", bad, 0);

    // Address wrap
    deque_i = 1'b0;
    do_reset();
    start_i = 1'b1; start_addr_i = 8'hFE; deque_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 8'hFE + 8'(i);
      mid();
      check("wrap_re",   sram_re_o,   1'b1);
      check("wrap_addr", sram_addr_o, a);
      step();
    end

    // Halt, drain, redirect to 0x20
    deque_i = 1'b0;
    do_reset();
    start_i = 1'b1; start_addr_i = 8'h30;
    step();
    start_i = 1'b0;
    mid();
    check("halt_pre_addr0", sram_addr_o, 8'h30);
    step();
    mid();
    check("halt_pre_addr1", sram_addr_o, 8'h31);
    step();
    halt_i = 1'b1;
    mid();
    check("halt_re",       sram_re_o,    1'b0);
    check("halt_enq",      fifo_enque_o, 1'b1);
    check("halt_enq_addr", fifo_addr_o,  8'h31);
    step();
    mid();
    check("halted_re",   sram_re_o, 1'b0);
    check("halted_busy", busy_o,    1'b1);
    step();
    deque_i = 1'b1;
    mark = deq_log.size();
    mid();
    check("drain_deq0", fifo_deque_o, 1'b1);
    step();
    mid();
    check("drain_deq1", fifo_deque_o, 1'b1);
    step();
    mid();
    check("drain_empty_deq", fifo_deque_o, 1'b0);
    check("drain_re",        sram_re_o,    1'b0);
    step();
    check("drain_head0", deq_log[mark],     8'h30);
    check("drain_head1", deq_log[mark + 1], 8'h31);
    deque_i = 1'b0;
    redirect_i = 1'b1; redirect_addr_i = 8'h20;
    mid();
    check("halt_redir_re", sram_re_o, 1'b0);
    step();
    redirect_i = 1'b0; halt_i = 1'b0;
    mid();
    check("halt_flush_clear", fifo_clear_o, 1'b1);
    step();
    mid();
    check("resume_re",   sram_re_o,   1'b1);
    check("resume_addr", sram_addr_o, 8'h20);
    step();

    // Asynchronous reset mid-fetch with two entries held
    do_reset();
    start_i = 1'b1; start_addr_i = 8'h50;
    step();
    start_i = 1'b0;
    step();
    step();
    step();
    mid();
    check("pre_areset_size", mdl_addr.size(), 2);
    check("pre_areset_busy", busy_o, 1'b1);
    #1 reset_n_i = 1'b0;
    #1;
    check("areset_re",    sram_re_o,    1'b0);
    check("areset_enq",   fifo_enque_o, 1'b0);
    check("areset_deq",   fifo_deque_o, 1'b0);
    check("areset_clear", fifo_clear_o, 1'b1);
    check("areset_busy",  busy_o,       1'b0);
    step();
    reset_n_i = 1'b1;
    start_i = 1'b1; start_addr_i = 8'h60; deque_i = 1'b1;
    step();
    start_i = 1'b0;
    mark = deq_log.size();
    mark2 = enq_log.size();
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 3; i++) begin
      check("new_stream_head", deq_log[mark + i], 8'h60 + 8'(i));
    end
    bad = 0;
    for (int k = mark2; k < enq_log.size(); k++) begin
      if (enq_log[k][7:4] != 4'h6) bad++;
    end
    check("new_stream_only", bad, 0);
    deque_i = 1'b0;

    check("fifo_overflow",  overflow_cnt,  0);
    check("fifo_underflow", underflow_cnt, 0);
    check("fifo_data",      data_err_cnt,  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer sitting between the instruction SRAM and the instruction FIFO (depth 2**LG_DEPTH, usable capacity 2**LG_DEPTH-1) of the 12-bit processor. It generates the sequential fetch PC and issues SRAM reads (1-cycle read latency). It enqueues returned {addr, data} pairs into the FIFO and throttles issue with an internal credit count so the FIFO never overflows. It also owns FIFO clearing on reset/idle and on branch redirect, and discards wrong-path responses.

Parameters:
I_WIDTH, 12, instruction width
A_WIDTH, 8, SRAM/PC address width
LG_DEPTH, 2, lg of FIFO storage depth; CAP = 2**LG_DEPTH-1 usable entries

Ports:
clk  input  1  clock, all state on posedge
reset_n_i  input  1  asynchronous active-low reset
start_i  input  1  begin fetching at start_addr_i (IDLE only)
start_addr_i  input  A_WIDTH  initial PC
redirect_i  input  1  branch/jump redirect request
redirect_addr_i  input  A_WIDTH  redirect target PC
halt_i  input  1  stop issuing new fetches
deque_i  input  1  consumer pops FIFO head
sram_re_o  output  1  SRAM read enable
sram_addr_o  output  A_WIDTH  SRAM read address (= pc_r)
sram_data_i  input  I_WIDTH  SRAM read data, valid the cycle after sram_re_o
fifo_enque_o  output  1  FIFO enque
fifo_addr_o  output  A_WIDTH  FIFO write address
fifo_data_o  output  I_WIDTH  FIFO write data (= sram_data_i)
fifo_deque_o  output  1  FIFO deque (filtered deque_i)
fifo_clear_o  output  1  FIFO clear
busy_o  output  1  state != IDLE

Behaviour:
- States: IDLE, FETCH, HALT, FLUSH. Reset (async, reset_n_i=0): state=IDLE, pc_r=0, occ_r=0, rsp_valid_r=0, rsp_addr_r=0.
- Reset output values: sram_re_o=0, fifo_enque_o=0, fifo_deque_o=0, fifo_clear_o=1, busy_o=0.
- fifo_clear_o = (state==IDLE)|(state==FLUSH). In these states, fifo_enque_o=0 and fifo_deque_o=0.
- IDLE: start_i -> FETCH, pc_r<=start_addr_i. redirect_i and halt_i are ignored.
- Credit: issue_ok = (occ_r + rsp_valid_r) < CAP. A same-cycle deque is NOT counted, so credit is conservative.
- FETCH issue: sram_re_o = (state==FETCH) & issue_ok & !halt_i & !redirect_i (combinational). On issue, pc_r<=pc_r+1 (wraps mod 2**A_WIDTH), rsp_valid_r<=1, rsp_addr_r<=pc_r; otherwise rsp_valid_r<=0.
- Response: fifo_enque_o = rsp_valid_r & (state!=FLUSH) & !(state==FETCH & redirect_i). fifo_addr_o=rsp_addr_r.
- fifo_deque_o = deque_i & (occ_r!=0) & state in {FETCH,HALT}. A deque on an empty FIFO is dropped.
- occ_r <= occ_r + fifo_enque_o - fifo_deque_o; it never exceeds CAP and never underflows.
- FETCH & halt_i -> HALT. No issue that cycle; a response already in flight is still enqueued.
- HALT: no issue; deques are honoured. Exit only via redirect_i -> FLUSH.
- Redirect (FETCH or HALT, cycle t): no issue in t; an in-flight response in t is killed (not enqueued); pc_r<=redirect_addr_i; state->FLUSH. Redirect beats halt_i in the same cycle.
- FLUSH (cycle t+1): fifo_clear_o=1, occ_r<=0, rsp_valid_r<=0; state->FETCH. First read at redirect_addr_i is issued in cycle t+2.
- redirect_i during FLUSH is ignored.
- Steady state with a deque every cycle: one fetch per cycle.
- Reset asserted mid-operation: immediate return to IDLE values. In-flight data is dropped, and the FIFO is cleared from the next clock edge while in IDLE.

Test Plan:
- Reset, then hold IDLE 3 cycles -> fifo_clear_o=1, sram_re_o=0, busy_o=0 throughout.
- start_i with start_addr_i=0x10, deque_i=0 -> reads issued to 0x10,0x11,0x12 on consecutive cycles; then sram_re_o=0, occ_r=3; FIFO holds {0x10,0x11,0x12} with their data and is never written while full.
- Same start, then deque_i=1 continuously -> one read per cycle; FIFO head addresses advance 0x10,0x11,... in order with no gaps or duplicates.
- Redirect to 0x40 while a read to 0x15 is in flight -> 0x15 is not enqueued; fifo_clear_o pulses 1 cycle; next sram_addr_o=0x40 two cycles after redirect; head after refill=0x40.
- start_addr_i=0xFE with free-running deque -> read sequence 0xFE,0xFF,0x00,0x01.
- halt_i in cycle t -> no reads from t on; the t-1 response is enqueued; deques drain occ_r to 0; redirect to 0x20 resumes fetching at 0x20.
- reset_n_i low mid-FETCH with occ_r=2 -> outputs return to reset values asynchronously; after start_i the FIFO contents seen are only the new stream.
